// File: rtl/ps2_drive_arbiter.sv
// PS/2 scan-code sequencer and drive-key arbiter: decodes E0/F0 prefixed make/break
// codes into held-key bits, then resolves opposing keys into accel/steer commands.
module ps2_drive_arbiter #(
   parameter int PREFIX_TIMEOUT = 1_000_000,
   parameter int TO_W           = 20
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [1:0] accel,
   output logic [1:0] steer,
   output logic       brake,
   output logic [4:0] keys_held,
   output logic       cmd_changed,
   output logic       seq_error
);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   localparam logic [7:0] CODE_EXT = 8'hE0;
   localparam logic [7:0] CODE_BRK = 8'hF0;

   state_t          state;
   logic [TO_W-1:0] to_cnt;
   logic            last_fb;   // 1: fwd pressed most recently, 0: back
   logic            last_lr;   // 1: left pressed most recently, 0: right
   logic [4:0]      set_mask;
   logic [4:0]      clr_mask;
   logic [4:0]      keys_nxt;
   logic [4:0]      new_press;
   logic            last_fb_nxt;
   logic            last_lr_nxt;
   logic [1:0]      accel_nxt;
   logic [1:0]      steer_nxt;
   logic            brake_nxt;

   // Bit order {brake, right, left, back, fwd}; unmapped codes (including prefixes) give 0.
   function automatic logic [4:0] map_std(input logic [7:0] code);
      case (code)
         8'h1D:   map_std = 5'b00001;
         8'h1B:   map_std = 5'b00010;
         8'h1C:   map_std = 5'b00100;
         8'h23:   map_std = 5'b01000;
         8'h29:   map_std = 5'b10000;
         default: map_std = 5'b00000;
      endcase
   endfunction

   function automatic logic [4:0] map_ext(input logic [7:0] code);
      case (code)
         8'h75:   map_ext = 5'b00001;
         8'h72:   map_ext = 5'b00010;
         8'h6B:   map_ext = 5'b00100;
         8'h74:   map_ext = 5'b01000;
         default: map_ext = 5'b00000;
      endcase
   endfunction

   // Opposing-pair resolution: {first, second} encoding, recency breaks ties.
   function automatic logic [1:0] arb_pair(input logic first, input logic second,
                                           input logic first_last);
      if (first && second) arb_pair = first_last ? 2'b10 : 2'b01;
      else if (first)      arb_pair = 2'b10;
      else if (second)     arb_pair = 2'b01;
      else                 arb_pair = 2'b00;
   endfunction

   always_comb begin
      set_mask = 5'b00000;
      clr_mask = 5'b00000;
      if (rx_valid) begin
         case (state)
            IDLE:    set_mask = map_std(rx_data);
            EXT:     set_mask = map_ext(rx_data);
            BRK:     clr_mask = map_std(rx_data);
            EXT_BRK: clr_mask = map_ext(rx_data);
            default: set_mask = 5'b00000;
         endcase
      end
   end

   assign keys_nxt  = (keys_held & ~clr_mask) | set_mask;
   assign new_press = set_mask & ~keys_held;

   always_comb begin
      last_fb_nxt = last_fb;
      last_lr_nxt = last_lr;
      if (new_press[0])      last_fb_nxt = 1'b1;
      else if (new_press[1]) last_fb_nxt = 1'b0;
      if (new_press[2])      last_lr_nxt = 1'b1;
      else if (new_press[3]) last_lr_nxt = 1'b0;
   end

   assign accel_nxt = keys_held[4] ? 2'b00 : arb_pair(keys_held[0], keys_held[1], last_fb);
   assign steer_nxt = arb_pair(keys_held[2], keys_held[3], last_lr);
   assign brake_nxt = keys_held[4];

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         to_cnt      <= '0;
         seq_error   <= 1'b0;
         keys_held   <= 5'b00000;
         last_fb     <= 1'b0;
         last_lr     <= 1'b0;
         accel       <= 2'b00;
         steer       <= 2'b00;
         brake       <= 1'b0;
         cmd_changed <= 1'b0;
      end else begin
         // Stage 1: prefix sequencing and held-key update
         if (rx_valid) begin
            to_cnt <= '0;
            case (state)
               IDLE: begin
                  if (rx_data == CODE_EXT)      state <= EXT;
                  else if (rx_data == CODE_BRK) state <= BRK;
                  else                          state <= IDLE;
               end
               EXT:     state <= (rx_data == CODE_BRK) ? EXT_BRK : IDLE;
               BRK: begin
                  state <= IDLE;
                  if (rx_data == CODE_EXT) seq_error <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (to_cnt == TO_W'(PREFIX_TIMEOUT)) begin
               state     <= IDLE;
               to_cnt    <= '0;
               seq_error <= 1'b1;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
         keys_held <= keys_nxt;
         last_fb   <= last_fb_nxt;
         last_lr   <= last_lr_nxt;

         // Stage 2: registered commands and change strobe
         accel       <= accel_nxt;
         steer       <= steer_nxt;
         brake       <= brake_nxt;
         cmd_changed <= (accel_nxt != accel) || (steer_nxt != steer) || (brake_nxt != brake);
      end
   end

endmodule

// File: tb/tb_ps2_drive_arbiter.sv
// Directed bench for ps2_drive_arbiter: expected commands are queued by the stimulus
// and popped by a monitor on every cmd_changed pulse.
module tb_ps2_drive_arbiter;

   localparam int PT = 20;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [1:0] accel;
   logic [1:0] steer;
   logic       brake;
   logic [4:0] keys_held;
   logic       cmd_changed;
   logic       seq_error;

   int n_tests = 0;
   int n_fail  = 0;
   logic [4:0] exp_q[$];   // {accel, steer, brake}

   ps2_drive_arbiter #(.PREFIX_TIMEOUT(PT), .TO_W(20)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .accel      (accel),
      .steer      (steer),
      .brake      (brake),
      .keys_held  (keys_held),
      .cmd_changed(cmd_changed),
      .seq_error  (seq_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic expect_cmd(input logic [1:0] a, input logic [1:0] s, input logic b);
      exp_q.push_back({a, s, b});
   endtask

   // Caller sits just after a clock edge; byte is sampled on the next edge.
   task automatic send(input logic [7:0] b, input logic [4:0] exp_keys);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      check($sformatf("keys_after_%h", b), {3'b0, keys_held}, {3'b0, exp_keys});
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input logic [1:0] a, input logic [1:0] s,
                          input logic b);
      check({name, "_accel"}, {6'b0, accel}, {6'b0, a});
      check({name, "_steer"}, {6'b0, steer}, {6'b0, s});
      check({name, "_brake"}, {7'b0, brake}, {7'b0, b});
   endtask

   // Monitor: every command-change pulse must match the next queued expectation.
   initial begin
      logic [4:0] e;
      forever begin
         @(negedge clk);
         if (reset && cmd_changed) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_cmd_changed: got %b%b%b, none expected (t=%0t)",
                        accel, steer, brake, $time);
            end else begin
               e = exp_q.pop_front();
               if ({accel, steer, brake} !== e) begin
                  n_fail++;
                  $display("FAIL cmd_value: got %b, expected %b (t=%0t)",
                           {accel, steer, brake}, e, $time);
               end
            end
         end
      end
   end

   initial begin
      // Reset state
      #2;
      chk_out("reset", 2'b00, 2'b00, 1'b0);
      check("reset_keys", {3'b0, keys_held}, 8'h00);
      check("reset_seq_error", {7'b0, seq_error}, 8'h00);
      check("reset_cmd_changed", {7'b0, cmd_changed}, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      settle();

      // Single forward key press and release
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'h1D, 5'b00001);
      settle();
      chk_out("fwd_press", 2'b10, 2'b00, 1'b0);
      expect_cmd(2'b00, 2'b00, 1'b0);
      send(8'hF0, 5'b00001);
      send(8'h1D, 5'b00000);
      settle();
      chk_out("fwd_release", 2'b00, 2'b00, 1'b0);

      // Extended up/down: recency then hand-back on release
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'hE0, 5'b00000);
      send(8'h75, 5'b00001);
      settle();
      expect_cmd(2'b01, 2'b00, 1'b0);
      send(8'hE0, 5'b00001);
      send(8'h72, 5'b00011);
      settle();
      chk_out("both_fb", 2'b01, 2'b00, 1'b0);
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'hE0, 5'b00011);
      send(8'hF0, 5'b00011);
      send(8'h72, 5'b00001);
      settle();
      chk_out("back_released", 2'b10, 2'b00, 1'b0);
      expect_cmd(2'b00, 2'b00, 1'b0);
      send(8'hE0, 5'b00001);
      send(8'hF0, 5'b00001);
      send(8'h75, 5'b00000);
      settle();

      // Brake overrides forward, steer untouched
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'h1D, 5'b00001);
      settle();
      expect_cmd(2'b00, 2'b00, 1'b1);
      send(8'h29, 5'b10001);
      settle();
      chk_out("brake_held", 2'b00, 2'b00, 1'b1);
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'hF0, 5'b10001);
      send(8'h29, 5'b00001);
      settle();
      chk_out("brake_released", 2'b10, 2'b00, 1'b0);
      expect_cmd(2'b00, 2'b00, 1'b0);
      send(8'hF0, 5'b00001);
      send(8'h1D, 5'b00000);
      settle();

      // Left then right, typematic left repeats must not steal steering
      expect_cmd(2'b00, 2'b10, 1'b0);
      send(8'h1C, 5'b00100);
      settle();
      expect_cmd(2'b00, 2'b01, 1'b0);
      send(8'h23, 5'b01100);
      settle();
      chk_out("left_then_right", 2'b00, 2'b01, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send(8'h1C, 5'b01100);
         settle();
      end
      chk_out("typematic_left", 2'b00, 2'b01, 1'b0);
      expect_cmd(2'b00, 2'b10, 1'b0);
      send(8'hF0, 5'b01100);
      send(8'h23, 5'b00100);
      settle();
      chk_out("right_released", 2'b00, 2'b10, 1'b0);
      expect_cmd(2'b00, 2'b00, 1'b0);
      send(8'hF0, 5'b00100);
      send(8'h1C, 5'b00000);
      settle();

      // Prefix timeout returns to IDLE and flags an error; lone 75 is ignored
      send(8'hE0, 5'b00000);
      repeat (PT + 3) @(posedge clk);
      #1;
      check("timeout_seq_error", {7'b0, seq_error}, 8'h01);
      send(8'h75, 5'b00000);
      settle();
      chk_out("lone_75", 2'b00, 2'b00, 1'b0);

      // Clear the sticky error, then land a byte on the exact timeout cycle
      reset = 1'b0;
      #1;
      check("reset_clears_error", {7'b0, seq_error}, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b1;
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'hE0, 5'b00000);
      repeat (PT) @(posedge clk);
      #1;
      send(8'h75, 5'b00001);
      check("boundary_no_error", {7'b0, seq_error}, 8'h00);
      settle();
      chk_out("boundary_up", 2'b10, 2'b00, 1'b0);
      expect_cmd(2'b00, 2'b00, 1'b0);
      send(8'hE0, 5'b00001);
      send(8'hF0, 5'b00001);
      send(8'h75, 5'b00000);
      settle();

      // Illegal F0 E0 order, then reset in the middle of a break sequence
      send(8'hF0, 5'b00000);
      send(8'hE0, 5'b00000);
      check("f0_e0_seq_error", {7'b0, seq_error}, 8'h01);
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'h1D, 5'b00001);
      settle();
      send(8'hF0, 5'b00001);
      #2;
      reset = 1'b0;
      #1;
      chk_out("async_reset", 2'b00, 2'b00, 1'b0);
      check("async_reset_keys", {3'b0, keys_held}, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b1;
      expect_cmd(2'b10, 2'b00, 1'b0);
      send(8'h1D, 5'b00001);
      settle();
      chk_out("after_reset", 2'b10, 2'b00, 1'b0);
      check("after_reset_seq_error", {7'b0, seq_error}, 8'h00);

      repeat (3) settle();
      check("pending_expectations", 8'(exp_q.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ps2_drive_arbiter.md
Name: ps2_drive_arbiter

Overview:
- Sequences the PS/2 scan-code stream coming out of PS2_Controller: tracks E0 (extended) and F0 (break) prefixes and keeps a held/released bit per drive key.
- Arbitrates conflicting keys into a single accel command and a single steer command for the vehicle datapath.
- Replaces edge-triggered decoding on the received-data strobe with a fully synchronous CLOCK_50 design.

Parameters:
- PREFIX_TIMEOUT, 1_000_000: CLOCK_50 cycles allowed between a prefix byte and the next byte before the sequence is abandoned (20 ms).
- TO_W, 20: width of the timeout counter; must satisfy 2^TO_W > PREFIX_TIMEOUT.

Ports:
- CLOCK_50 input 1: system clock; all state updates on its rising edge.
- reset input 1: asynchronous, active-low reset.
- rx_data input 8: byte from PS2_Controller.received_data.
- rx_valid input 1: one-cycle strobe from PS2_Controller.received_data_en; rx_data is valid only in that cycle.
- accel output 2: 2'b10 forward, 2'b01 backward, 2'b00 coast/brake.
- steer output 2: 2'b10 left, 2'b01 right, 2'b00 straight.
- brake output 1: high while the brake key is held.
- keys_held output 5: {brake, right, left, back, fwd} held bits.
- cmd_changed output 1: one-cycle pulse when accel, steer or brake changes value.
- seq_error output 1: sticky; set on prefix timeout or on an illegal prefix order; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): FSM in IDLE, timeout counter 0, keys_held 0, accel 00, steer 00, brake 0, cmd_changed 0, seq_error 0.
- Key map (make codes):
  - fwd: 1D (W) or E0 75 (up arrow).
  - back: 1B (S) or E0 72 (down arrow).
  - left: 1C (A) or E0 6B (left arrow).
  - right: 23 (D) or E0 74 (right arrow).
  - brake: 29 (space).
  - Any other code is ignored: no state change, no error.
- A non-extended 72, 75, 6B or 74 is not a drive key and is ignored.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen). Only cycles with rx_valid=1 cause transitions.
  - IDLE: E0 -> EXT; F0 -> BRK; mapped non-extended code -> set its held bit, stay in IDLE.
  - EXT: F0 -> EXT_BRK; mapped extended code -> set its held bit, go to IDLE; any other byte -> IDLE.
  - BRK: mapped non-extended code -> clear its held bit, go to IDLE; any other byte except E0 -> IDLE; E0 -> IDLE and set seq_error (illegal order F0 E0).
  - EXT_BRK: mapped extended code -> clear its held bit, go to IDLE; any other byte -> IDLE.
- Typematic repeats (the same make code arriving again) re-set an already-set bit. They do not change arbitration order.
- Timeout:
  - The counter runs only in EXT, BRK and EXT_BRK, and resets to 0 on every rx_valid.
  - When it reaches PREFIX_TIMEOUT: go to IDLE, set seq_error, keys_held unchanged.
- Arbitration (recency wins):
  - last_fb and last_lr registers record which of the opposing pair was most recently newly pressed (bit transition 0->1).
  - accel = 00 if brake is held. Otherwise: fwd only -> 10; back only -> 01; both held -> direction given by last_fb; neither held -> 00.
  - steer: same rules using left/right and last_lr; brake does not affect steer.
  - Releasing the winner of a held pair hands the command to the still-held opposing key.
- Latency: a byte with rx_valid in cycle N updates keys_held at the N+1 edge. accel, steer and brake are registered from keys_held, so they reflect it at the N+2 edge. cmd_changed pulses for exactly one cycle at N+2 when any of them changes.
- Simultaneous events: one byte per rx_valid, so there are no same-cycle key conflicts. If the timeout expires in the same cycle as rx_valid, the byte takes priority and no error is set.
- Reset mid-sequence: all held keys are cleared and the outputs return to 00/00/0 immediately (asynchronously).

Test Plan:
- Send 1D -> keys_held=00001, accel=10 two cycles after the strobe, cmd_changed one pulse. Then send F0 1D -> accel=00, one more pulse.
- Send E0 75, then E0 72 (both held) -> accel=01 (back pressed most recently). Then send E0 F0 72 -> accel=10.
- Hold 1D, send 29 -> accel=00, brake=1. Then send F0 29 -> accel=10, brake=0. steer stays 00 throughout.
- Send 1C then 23 -> steer=01. Repeat 1C five times (typematic) -> steer stays 01, no cmd_changed pulse.
- Send E0 then wait PREFIX_TIMEOUT cycles -> FSM IDLE, seq_error=1. A following 75 alone is ignored (not extended) and accel stays 00.
- Send F0 E0 -> seq_error=1. Hold 1D, then assert reset low mid-sequence -> accel=00 and keys_held=0 immediately. After release, send 1D -> accel=10 and seq_error=0.
